// File: rtl/n64_vmode_seq_pkg.sv
// Shared video-mode sequencer definitions: state encodings, parameter defaults
// and the reset value of the locked video info.
package n64_vmode_seq_pkg;

    typedef enum logic [1:0] {
        ST_NOVIDEO = 2'd0,
        ST_QUAL    = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_CHANGE  = 2'd3
    } vmode_state_t;

    localparam int SETTLE_FRAMES_DEF   = 4;
    localparam int DEBOUNCE_FRAMES_DEF = 2;
    localparam int RST_HOLD_CYCLES_DEF = 16;

    localparam logic [3:0] VINFO_LOCK_RST = 4'b0101;

endpackage

// File: rtl/n64_vsync_frame_cnt.sv
// Saturating frame counter: advances on a qualified vsync event, sync clear wins.
module n64_vsync_frame_cnt #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         VCLK,
    input  logic         nRST,
    input  logic         clr,
    input  logic         evt,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] CNT_MAX = W'(MAX);

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (evt && inc && (cnt != CNT_MAX))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/n64_vmode_seq.sv
// Video-mode lock sequencer: qualifies a stable mode over several vsyncs,
// debounces mode changes and holds the pixel pipeline in reset across them.
module n64_vmode_seq
    import n64_vmode_seq_pkg::*;
#(
    parameter int SETTLE_FRAMES   = SETTLE_FRAMES_DEF,
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF,
    parameter int RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF
) (
    input  logic       VCLK,
    input  logic       nRST,
    input  logic       nVDSYNC,
    input  logic [3:0] Sync_pre,
    input  logic [3:0] Sync_cur,
    input  logic [3:0] vinfo_i,
    input  logic       force_resync,
    output logic       nRST_pp,
    output logic [3:0] vinfo_lock_o,
    output logic       vmode_chg_o,
    output logic [1:0] state_o
);
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_FRAMES - 1);
    localparam logic [1:0] DEB_LAST    = 2'(DEBOUNCE_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(RST_HOLD_CYCLES - 1);

    vmode_state_t state, state_nxt;
    logic [2:0]   cand_mode, cand_nxt;
    logic [7:0]   hold_cnt, hold_nxt;
    logic [2:0]   settle_cnt;
    logic [1:0]   deb_cnt;
    logic         vsync_evt, vid, cand_match, lock_match;
    logic         settle_clr, deb_clr;
    logic         unused_sync;

    assign vsync_evt   = ~nVDSYNC & Sync_pre[3] & ~Sync_cur[3];
    assign vid         = vinfo_i[3];
    assign cand_match  = (vinfo_i[2:0] == cand_mode);
    assign lock_match  = (vinfo_i[2:0] == vinfo_lock_o[2:0]);
    assign unused_sync = ^{Sync_pre[2:0], Sync_cur[2:0]};
    assign state_o     = state;

    // A mismatching vsync restarts qualification rather than counting
    assign settle_clr = (state != ST_QUAL) | ~vid | force_resync | (vsync_evt & ~cand_match);
    assign deb_clr    = (state != ST_LOCKED) | ~vid | force_resync | (vsync_evt & lock_match);

    n64_vsync_frame_cnt #(.W(3), .MAX(SETTLE_FRAMES)) u_settle (
        .VCLK (VCLK),
        .nRST (nRST),
        .clr  (settle_clr),
        .evt  (vsync_evt),
        .inc  (cand_match),
        .cnt  (settle_cnt)
    );

    n64_vsync_frame_cnt #(.W(2), .MAX(DEBOUNCE_FRAMES)) u_debounce (
        .VCLK (VCLK),
        .nRST (nRST),
        .clr  (deb_clr),
        .evt  (vsync_evt),
        .inc  (~lock_match),
        .cnt  (deb_cnt)
    );

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand_mode;
        hold_nxt  = 8'd0;
        if (!vid) begin
            state_nxt = ST_NOVIDEO;
        end else begin
            case (state)
                ST_NOVIDEO: begin
                    if (!force_resync) begin
                        state_nxt = ST_QUAL;
                        cand_nxt  = vinfo_i[2:0];
                    end
                end
                ST_QUAL: begin
                    if (force_resync)
                        state_nxt = ST_QUAL;
                    else if (vsync_evt && !cand_match)
                        cand_nxt = vinfo_i[2:0];
                    else if (vsync_evt && settle_cnt == SETTLE_LAST)
                        state_nxt = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (force_resync || (vsync_evt && !lock_match && deb_cnt == DEB_LAST))
                        state_nxt = ST_CHANGE;
                end
                ST_CHANGE: begin
                    if (force_resync) begin
                        hold_nxt = 8'd0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_nxt = ST_QUAL;
                        cand_nxt  = vinfo_i[2:0];
                    end else begin
                        hold_nxt = hold_cnt + 8'd1;
                    end
                end
                default: state_nxt = ST_NOVIDEO;
            endcase
        end
    end

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            state        <= ST_NOVIDEO;
            cand_mode    <= 3'd0;
            hold_cnt     <= 8'd0;
            nRST_pp      <= 1'b0;
            vinfo_lock_o <= VINFO_LOCK_RST;
            vmode_chg_o  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cand_mode   <= cand_nxt;
            hold_cnt    <= hold_nxt;
            // Pipeline leaves reset only once LOCKED has been held a full cycle
            nRST_pp     <= (state == ST_LOCKED) && (state_nxt == ST_LOCKED);
            vmode_chg_o <= (state != ST_LOCKED) && (state_nxt == ST_LOCKED);
            if (!vid)
                vinfo_lock_o[3] <= 1'b0;
            else if (state != ST_LOCKED && state_nxt == ST_LOCKED)
                vinfo_lock_o <= {1'b1, cand_mode};
        end
    end

endmodule

// File: tb/tb_n64_vmode_seq.sv
// Directed bench for n64_vmode_seq: lock, debounce, mode change, video loss, resets.
module tb_n64_vmode_seq;

    logic       VCLK = 1'b0;
    logic       nRST;
    logic       nVDSYNC;
    logic [3:0] Sync_pre, Sync_cur, vinfo_i;
    logic       force_resync;
    logic       nRST_pp;
    logic [3:0] vinfo_lock_o;
    logic       vmode_chg_o;
    logic [1:0] state_o;

    int vectors = 0;
    int errors  = 0;

    always #5 VCLK = ~VCLK;

    n64_vmode_seq dut (
        .VCLK         (VCLK),
        .nRST         (nRST),
        .nVDSYNC      (nVDSYNC),
        .Sync_pre     (Sync_pre),
        .Sync_cur     (Sync_cur),
        .vinfo_i      (vinfo_i),
        .force_resync (force_resync),
        .nRST_pp      (nRST_pp),
        .vinfo_lock_o (vinfo_lock_o),
        .vmode_chg_o  (vmode_chg_o),
        .state_o      (state_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge VCLK);
        #1;
    endtask

    // One-cycle vsync qualifier: nVSYNC falls between previous and current nibble
    task automatic vsync(input logic [3:0] vi);
        vinfo_i  = vi;
        nVDSYNC  = 1'b0;
        Sync_pre = 4'b1000;
        Sync_cur = 4'b0000;
        tick();
        nVDSYNC  = 1'b1;
        Sync_pre = 4'hF;
        Sync_cur = 4'hF;
    endtask

    task automatic count_change(output int n, output logic low_ok);
        n      = 1;
        low_ok = (nRST_pp === 1'b0);
        for (int i = 0; i < 64; i++) begin
            tick();
            if (state_o !== 2'd3) break;
            n++;
            if (nRST_pp !== 1'b0) low_ok = 1'b0;
        end
    endtask

    initial begin
        int   n;
        logic low_ok;
        nRST = 1'b1; nVDSYNC = 1'b1; Sync_pre = 4'hF; Sync_cur = 4'hF;
        vinfo_i = 4'b0000; force_resync = 1'b0;
        #3 nRST = 1'b0;
        tick(); tick();
        chk("rst_state", state_o, 2'd0);
        chk("rst_nrst_pp", nRST_pp, 1'b0);
        chk("rst_lock", vinfo_lock_o, 4'b0101);
        chk("rst_chg", vmode_chg_o, 1'b0);
        nRST = 1'b1;
        tick();
        chk("novid_hold", state_o, 2'd0);

        // stable NTSC 240p locks on the 4th vsync
        vinfo_i = 4'b1000;
        tick();
        chk("enter_qual", state_o, 2'd1);
        for (int i = 0; i < 3; i++) vsync(4'b1000);
        chk("qual_3vs", state_o, 2'd1);
        vsync(4'b1000);
        chk("lock_state", state_o, 2'd2);
        chk("lock_chg", vmode_chg_o, 1'b1);
        chk("lock_vinfo", vinfo_lock_o, 4'b1000);
        chk("lock_pp_low", nRST_pp, 1'b0);
        tick();
        chk("chg_pulse_end", vmode_chg_o, 1'b0);
        chk("pp_rise", nRST_pp, 1'b1);

        // single-vsync glitches are debounced away
        vsync(4'b1001);
        vsync(4'b1000);
        vsync(4'b1001);
        vsync(4'b1000);
        chk("glitch_state", state_o, 2'd2);
        chk("glitch_pp", nRST_pp, 1'b1);

        // switch to PAL: change after 2 vsyncs, 16-cycle hold, relock after 4
        vsync(4'b1110);
        chk("pal_1vs", state_o, 2'd2);
        vsync(4'b1110);
        chk("pal_change", state_o, 2'd3);
        count_change(n, low_ok);
        chk("hold_len", 8'(n), 8'd16);
        chk("hold_low", low_ok, 1'b1);
        chk("hold_to_qual", state_o, 2'd1);
        chk("lock_kept_qual", vinfo_lock_o, 4'b1000);
        for (int i = 0; i < 3; i++) vsync(4'b1110);
        chk("pal_qual3", state_o, 2'd1);
        vsync(4'b1110);
        chk("pal_relock", state_o, 2'd2);
        chk("pal_lock_vinfo", vinfo_lock_o, 4'b1110);
        chk("pal_chg", vmode_chg_o, 1'b1);

        // force_resync from LOCKED, and restarting the hold inside CHANGE
        tick();
        force_resync = 1'b1; tick(); force_resync = 1'b0;
        chk("force_change", state_o, 2'd3);
        for (int i = 0; i < 5; i++) tick();
        force_resync = 1'b1; tick(); force_resync = 1'b0;
        count_change(n, low_ok);
        chk("hold_restart", 8'(n), 8'd16);

        // video loss at settle count 3
        for (int i = 0; i < 3; i++) vsync(4'b1110);
        chk("loss_pre", state_o, 2'd1);
        vinfo_i = 4'b0110;
        tick();
        chk("loss_state", state_o, 2'd0);
        chk("loss_pp", nRST_pp, 1'b0);
        chk("loss_lock", vinfo_lock_o, 4'b0110);

        // mode change during QUAL reloads candidate and restarts count
        vinfo_i = 4'b1000;
        tick();
        vsync(4'b1000); vsync(4'b1000);
        vsync(4'b1001);
        for (int i = 0; i < 3; i++) vsync(4'b1001);
        chk("reload_qual", state_o, 2'd1);
        vsync(4'b1001);
        chk("reload_lock", state_o, 2'd2);
        chk("reload_vinfo", vinfo_lock_o, 4'b1001);

        // video loss beats force_resync
        tick();
        vinfo_i = 4'b0001; force_resync = 1'b1;
        tick();
        force_resync = 1'b0;
        chk("prio_state", state_o, 2'd0);
        chk("prio_lock", vinfo_lock_o, 4'b0001);

        // async reset in the middle of CHANGE
        vinfo_i = 4'b1000;
        tick();
        for (int i = 0; i < 4; i++) vsync(4'b1000);
        chk("pre_arst_lock", state_o, 2'd2);
        force_resync = 1'b1; tick(); force_resync = 1'b0;
        tick(); tick(); tick();
        chk("pre_arst_chg", state_o, 2'd3);
        #2 nRST = 1'b0;
        #1;
        chk("arst_state", state_o, 2'd0);
        chk("arst_pp", nRST_pp, 1'b0);
        chk("arst_lock", vinfo_lock_o, 4'b0101);
        chk("arst_chg", vmode_chg_o, 1'b0);
        #1 nRST = 1'b1;
        tick();
        chk("arst_requal", state_o, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/n64_vmode_seq.md
N64_VMODE_SEQ -- requirements
Module: n64_vmode_seq

Interface
REQ-001 SHALL have parameter SETTLE_FRAMES, default 4, consecutive identical-mode vsyncs required before lock (range 1..7).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 2, consecutive differing-mode vsyncs required to declare a mode change (range 1..3).
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 16, VCLK cycles nRST_pp is held low in CHANGE (range 1..255).
REQ-004 SHALL have port VCLK, input, 1, sole clock.
REQ-005 SHALL have port nRST, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port nVDSYNC, input, 1, low marks a sync/data qualifier cycle.
REQ-007 SHALL have port Sync_pre, input, 4, previous sync nibble; bit 3 is nVSYNC.
REQ-008 SHALL have port Sync_cur, input, 4, current sync nibble; bit 3 is nVSYNC.
REQ-009 SHALL have port vinfo_i, input, 4, raw video info {vdata_detected, pal_is_240p, palmode, n64_480i}.
REQ-010 SHALL have port force_resync, input, 1, single-cycle request to drop lock and requalify.
REQ-011 SHALL have port nRST_pp, output, 1, active-low reset for the downstream pixel pipeline.
REQ-012 SHALL have port vinfo_lock_o, output, 4, qualified video info, same bit order as vinfo_i.
REQ-013 SHALL have port vmode_chg_o, output, 1, one-cycle pulse when a new mode is locked.
REQ-014 SHALL have port state_o, output, 2, current state encoding.

Function
REQ-015 SHALL define vsync_evt = !nVDSYNC & Sync_pre[3] & !Sync_cur[3]; all frame counting uses vsync_evt only.
REQ-016 SHALL compare mode = vinfo_i[2:0]; vinfo_i[3] is the video-present flag.
REQ-017 SHALL implement states NOVIDEO=0, QUAL=1, LOCKED=2, CHANGE=3.
REQ-018 NOVIDEO: nRST_pp=0; when vinfo_i[3]=1, go to QUAL with settle count 0 and cand_mode captured from mode.
REQ-019 QUAL: on vsync_evt with mode==cand_mode, increment settle count; with mode!=cand_mode, reload cand_mode and clear the count.
REQ-020 QUAL: when settle count reaches SETTLE_FRAMES, go to LOCKED; vinfo_lock_o={1,cand_mode} and vmode_chg_o=1 on the same cycle LOCKED is entered.
REQ-021 LOCKED: nRST_pp=1 starting one cycle after entry; on each vsync_evt with mode!=locked mode, increment debounce count, otherwise clear it.
REQ-022 LOCKED: when debounce count reaches DEBOUNCE_FRAMES, or force_resync=1, go to CHANGE.
REQ-023 CHANGE: nRST_pp=0 for exactly RST_HOLD_CYCLES cycles, then go to QUAL with cand_mode=mode and count 0.
REQ-024 Any state: vinfo_i[3]=0 SHALL force NOVIDEO next cycle, clear vinfo_lock_o[3], and drive nRST_pp=0; this has priority over all other events.
REQ-025 Priority order SHALL be: video loss, then force_resync, then debounce expiry, then settle expiry.
REQ-026 force_resync in NOVIDEO, QUAL or CHANGE SHALL restart that state's counter, with no state change.
REQ-027 All counters SHALL saturate, never wrap; vinfo_lock_o[2:0] SHALL change only on entry to LOCKED.
REQ-028 All outputs SHALL be registered; state_o SHALL reflect the current state register.

Reset
REQ-029 Async reset SHALL set state NOVIDEO, nRST_pp=0, vinfo_lock_o=4'b0101, vmode_chg_o=0, and all counters and cand_mode to 0.
REQ-030 Reset asserted mid-operation SHALL abort the current state immediately; after release, requalification starts from NOVIDEO.

Structure
REQ-031 State encodings and the default values of SETTLE_FRAMES, DEBOUNCE_FRAMES and RST_HOLD_CYCLES SHALL live in the shared video-parameter include.
REQ-032 A single sub-module, n64_vsync_frame_cnt (vsync_evt-qualified saturating counter with clear), SHALL be instantiated twice: settle and debounce.

Verification
REQ-033 Stable NTSC 240p (vinfo_i=4'b1000) for 4 vsyncs -> LOCKED after the 4th; vmode_chg_o one pulse; vinfo_lock_o=4'b1000; nRST_pp rises next cycle.
REQ-034 Locked NTSC, then mode toggles 480i for 1 vsync only -> no state change; nRST_pp stays 1.
REQ-035 Locked NTSC, switch to PAL (4'b1110) for 2 vsyncs -> CHANGE; nRST_pp low 16 cycles; relock 4'b1110 after 4 further vsyncs.
REQ-036 vinfo_i[3] drops during QUAL at settle count 3 -> NOVIDEO next cycle; nRST_pp=0; vinfo_lock_o[3]=0.
REQ-037 force_resync and vinfo_i[3]=0 in the same cycle while LOCKED -> NOVIDEO, not CHANGE.
REQ-038 nRST pulsed low during CHANGE -> all outputs return to reset values asynchronously.
